// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential EX-stage ALU.
//   ALU_* : 3-bit ALUCtrl opcode encodings
//   state_t : top-level handshake FSM states
//   md_op_t : operation selector handed to the multiply/divide engine
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_DIVU = 3'b100;
    localparam logic [2:0] ALU_REMU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_REM
    } md_op_t;

    // Operations that run on the iterative engine instead of in one cycle.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic md_op_t md_op_of(input logic [2:0] op);
        case (op)
            ALU_MUL:  return MD_MUL;
            ALU_DIVU: return MD_DIV;
            default:  return MD_REM;
        endcase
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv -- iterative shift-add multiplier / restoring unsigned divider.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : load operands and begin (ignored while busy by the top FSM)
//   op_i           : MD_MUL, MD_DIV or MD_REM
//   a_i, b_i       : operands, sampled only when start_i is high
//   done_o         : high during the final iteration cycle
//   result_o       : value after the current iteration; valid when done_o is high
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    // acc  : product accumulator (MUL) or partial remainder (DIV/REM)
    // sh   : multiplier shifted right (MUL) or dividend-in / quotient-out (DIV/REM)
    // opnd : multiplicand shifted left (MUL) or divisor (DIV/REM)
    logic [WIDTH-1:0] acc_q,  acc_d;
    logic [WIDTH-1:0] sh_q,   sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             busy_q, busy_d;
    md_op_t           op_q,   op_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] step_acc, step_sh, step_opnd;

    // One iteration of whichever algorithm is in flight.
    always_comb begin
        rem_shift = {acc_q, sh_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
        step_opnd = opnd_q;
        if (op_q == MD_MUL) begin
            step_acc  = acc_q + (sh_q[0] ? opnd_q : '0);
            step_sh   = sh_q >> 1;
            step_opnd = opnd_q << 1;
        end else if (rem_ge) begin
            // Divisor of 0 always lands here, giving all-ones quotient and remainder = A.
            step_acc = rem_diff;
            step_sh  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_shift[WIDTH-1:0];
            step_sh  = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        sh_d   = sh_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        op_d   = op_q;
        if (start_i) begin
            acc_d  = '0;
            sh_d   = (op_i == MD_MUL) ? b_i : a_i;
            opnd_d = (op_i == MD_MUL) ? a_i : b_i;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
            op_d   = op_i;
        end else if (busy_q) begin
            acc_d  = step_acc;
            sh_d   = step_sh;
            opnd_d = step_opnd;
            cnt_d  = cnt_q - 1'b1;
            busy_d = (cnt_q != '0);
        end
    end

    // NOTE: the datapath registers are reset along with the control bits; there is
    // no memory array here, and it keeps X out of the result after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            op_q   <= MD_MUL;
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            op_q   <= op_d;
        end
    end

    // The top registers result_o on the done cycle, so the last iteration is included.
    assign done_o   = busy_q && (cnt_q == '0);
    assign result_o = (op_q == MD_DIV) ? step_sh : step_acc;

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- multi-cycle EX-stage ALU with valid/ready handshakes.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : operation handshake (data1_i, data2_i, ALUCtrl_i)
//   out_valid_o / out_ready_i : result handshake (data_o, Zero_o, Ovf_o)
// AND/OR/ADD/SUB/SLT finish in one cycle; MUL/DIVU/REMU take WIDTH cycles in seq_muldiv.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             Ovf_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             zero_q,  zero_d;
    logic             ovf_q,   ovf_d;

    logic             accept;
    logic             iter_op;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign iter_op = is_iterative(ALUCtrl_i);
    assign sum     = data1_i + data2_i;
    assign diff    = data1_i - data2_i;

    // NOTE: every variable assigned in an always_comb gets a default first, so no
    // path through the case can leave a latch behind.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl_i)
            ALU_AND: alu_res = data1_i & data2_i;
            ALU_OR:  alu_res = data1_i | data2_i;
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != data1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != data1_i[WIDTH-1]);
            end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: alu_res = '0;
        endcase
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (accept && iter_op),
        .op_i     (md_op_of(ALUCtrl_i)),
        .a_i      (data1_i),
        .b_i      (data2_i),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // FSM: state register
    // NOTE: sequential blocks use non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state. An accept out of DONE retires the old result on the same edge.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = iter_op ? S_BUSY : S_DONE;
        end else begin
            case (state_q)
                S_BUSY:  if (md_done) state_d = S_DONE;
                S_DONE:  if (out_ready_i) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM: outputs. out_ready_i -> in_ready_o is the only combinational output path.
    always_comb begin
        in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
        out_valid_o = (state_q == S_DONE);
        accept      = in_valid_i && in_ready_o;
    end

    // Result registers: flags are captured with the data so they always describe data_o.
    always_comb begin
        data_d = data_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (accept && !iter_op) begin
            data_d = alu_res;
            zero_d = (alu_res == '0);
            ovf_d  = alu_ovf;
        end else if ((state_q == S_BUSY) && md_done) begin
            data_d = md_result;
            zero_d = (md_result == '0);
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign Zero_o = zero_q;
    assign Ovf_o  = ovf_q;

endmodule
